// File: rtl/legv8_ctrl_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 controller:
// FSM states, opcode encodings, ALU operation codes and opcode classification.
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    EXEC_R,
    R_WB,
    CBZ,
    JUMP,
    ILLEGAL
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_LDUR,
    CLS_STUR,
    CLS_CBZ,
    CLS_B,
    CLS_BAD
  } op_class_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // CBZ and B carry immediate bits in the low opcode field, so only prefixes match
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  function automatic op_class_t classify(input logic [10:0] op);
    op_class_t cls;
    cls = CLS_BAD;
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR)
      cls = CLS_R;
    else if (op == OP_LDUR)
      cls = CLS_LDUR;
    else if (op == OP_STUR)
      cls = CLS_STUR;
    else if (op[10:3] == OP_CBZ_PFX)
      cls = CLS_CBZ;
    else if (op[10:5] == OP_B_PFX)
      cls = CLS_B;
    return cls;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational mapping from an R-type opcode to the ALU operation code.
module alu_ctrl_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output logic [3:0]  alu_sel
);

  always_comb begin
    alu_sel = ALU_ADD;
    case (opcode)
      OP_ADD:  alu_sel = ALU_ADD;
      OP_SUB:  alu_sel = ALU_SUB;
      OP_AND:  alu_sel = ALU_AND;
      OP_ORR:  alu_sel = ALU_OR;
      default: alu_sel = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle LEGv8 control unit: Moore FSM sequencing fetch/decode/execute,
// with an opcode latched at DECODE and a counter of retired instructions.
module mc_control
  import legv8_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] opcode,
  input  logic        z,
  input  logic        mem_ready,
  output logic [3:0]  ALU_Sel,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        reg2loc,
  output logic        illegal,
  output logic [31:0] retired
);

  state_t      state_reg;
  logic [10:0] opcode_reg;
  logic [31:0] retired_reg;
  logic [3:0]  exec_alu_sel;
  op_class_t   dec_class;
  op_class_t   held_class;

  logic pc_write_dec;
  logic ir_write_dec;
  logic mem_write_dec;
  logic reg_write_dec;

  alu_ctrl_decode u_alu_ctrl_decode (
    .opcode  (opcode_reg),
    .alu_sel (exec_alu_sel)
  );

  // DECODE steers on the live opcode; later states only see the latched copy
  assign dec_class  = classify(opcode);
  assign held_class = classify(opcode_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FETCH;
      opcode_reg  <= '0;
      retired_reg <= '0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (mem_ready) state_reg <= DECODE;
        end
        DECODE: begin
          opcode_reg <= opcode;
          case (dec_class)
            CLS_R:              state_reg <= EXEC_R;
            CLS_LDUR, CLS_STUR: state_reg <= MEM_ADDR;
            CLS_CBZ:            state_reg <= CBZ;
            CLS_B:              state_reg <= JUMP;
            default:            state_reg <= ILLEGAL;
          endcase
        end
        MEM_ADDR: begin
          state_reg <= (held_class == CLS_STUR) ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          if (mem_ready) state_reg <= MEM_WB;
        end
        MEM_WR: begin
          if (mem_ready) begin
            state_reg   <= FETCH;
            retired_reg <= retired_reg + 32'd1;
          end
        end
        EXEC_R: begin
          state_reg <= R_WB;
        end
        MEM_WB, R_WB, CBZ, JUMP: begin
          state_reg   <= FETCH;
          retired_reg <= retired_reg + 32'd1;
        end
        ILLEGAL: begin
          state_reg <= FETCH;
        end
        default: begin
          state_reg <= FETCH;
        end
      endcase
    end
  end

  always_comb begin
    ALU_Sel       = ALU_AND;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_write_dec  = 1'b0;
    pc_src        = 1'b0;
    ir_write_dec  = 1'b0;
    mem_read      = 1'b0;
    mem_write_dec = 1'b0;
    reg_write_dec = 1'b0;
    mem_to_reg    = 1'b0;
    reg2loc       = 1'b0;
    illegal       = 1'b0;
    case (state_reg)
      FETCH: begin
        mem_read     = 1'b1;
        ALU_Sel      = ALU_ADD;
        alu_src_b    = 2'b01;
        ir_write_dec = mem_ready;
        pc_write_dec = mem_ready;
      end
      DECODE: begin
        ALU_Sel   = ALU_ADD;
        alu_src_b = 2'b11;
        reg2loc   = (dec_class == CLS_STUR) || (dec_class == CLS_CBZ);
      end
      MEM_ADDR: begin
        ALU_Sel   = ALU_ADD;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_RD: begin
        mem_read = 1'b1;
      end
      MEM_WB: begin
        reg_write_dec = 1'b1;
        mem_to_reg    = 1'b1;
      end
      MEM_WR: begin
        mem_write_dec = 1'b1;
        reg2loc       = 1'b1;
      end
      EXEC_R: begin
        ALU_Sel   = exec_alu_sel;
        alu_src_a = 1'b1;
      end
      R_WB: begin
        reg_write_dec = 1'b1;
      end
      CBZ: begin
        ALU_Sel      = ALU_PASSB;
        alu_src_a    = 1'b1;
        reg2loc      = 1'b1;
        pc_src       = 1'b1;
        pc_write_dec = z;
      end
      JUMP: begin
        pc_write_dec = 1'b1;
        pc_src       = 1'b1;
      end
      ILLEGAL: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b0;
      end
    endcase
  end

  // Architectural-state writes are blocked for as long as reset is held
  assign pc_write  = pc_write_dec  & rst_n;
  assign ir_write  = ir_write_dec  & rst_n;
  assign mem_write = mem_write_dec & rst_n;
  assign reg_write = reg_write_dec & rst_n;
  assign retired   = retired_reg;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: each instruction is expanded into its
// expected per-cycle control vectors and compared cycle by cycle.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] opcode = '0;
  logic        z = 1'b0;
  logic        mem_ready = 1'b1;
  logic [3:0]  ALU_Sel;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_write, pc_src, ir_write, mem_read, mem_write;
  logic        reg_write, mem_to_reg, reg2loc, illegal;
  logic [31:0] retired;

  mc_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .z          (z),
    .mem_ready  (mem_ready),
    .ALU_Sel    (ALU_Sel),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .reg2loc    (reg2loc),
    .illegal    (illegal),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_BAD = 5;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_retired = '0;
  logic [15:0] obs;
  logic [10:0] r_ops [4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};

  assign obs = {ALU_Sel, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
                mem_read, mem_write, reg_write, mem_to_reg, reg2loc, illegal};

  function automatic int kind(input logic [10:0] op);
    casez (op)
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: return K_R;
      11'b11111000010:                  return K_LD;
      11'b11111000000:                  return K_ST;
      11'b10110100???:                  return K_CBZ;
      11'b000101?????:                  return K_B;
      default:                          return K_BAD;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [10:0] op);
    case (op)
      11'b11001011000: return 4'b0110;
      11'b10001010000: return 4'b0000;
      11'b10101010000: return 4'b0001;
      default:         return 4'b0010;
    endcase
  endfunction

  // Expected control vector in the same field order as obs
  function automatic logic [15:0] ov(input logic [3:0] alu, input int a, input int b,
                                     input int pcw, input int pcs, input int irw,
                                     input int mr, input int mw, input int rw,
                                     input int m2r, input int r2l, input int ill);
    return {alu, a[0], b[1:0], pcw[0], pcs[0], irw[0], mr[0], mw[0], rw[0],
            m2r[0], r2l[0], ill[0]};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [10:0] rop();
    return 11'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic cyc(input string tag, input logic mr, input logic zz,
                     input logic [10:0] op, input logic [15:0] e);
    @(negedge clk);
    mem_ready = mr;
    z         = zz;
    opcode    = op;
    #1;
    chk(tag, {16'h0, obs}, {16'h0, e});
    @(posedge clk);
  endtask

  task automatic exec_instr(input logic [10:0] op, input int fw, input int mwait,
                            input logic zz);
    int k;
    k = kind(op);
    for (int i = 0; i < fw; i++)
      cyc("fetch_wait", 1'b0, rb(), rop(), ov(4'b0010, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    cyc("fetch", 1'b1, rb(), rop(), ov(4'b0010, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
    cyc("decode", rb(), rb(), op,
        ov(4'b0010, 0, 3, 0, 0, 0, 0, 0, 0, 0, (k == K_ST || k == K_CBZ) ? 1 : 0, 0));
    case (k)
      K_R: begin
        cyc("exec_r", rb(), rb(), rop(), ov(alu_of(op), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("r_wb", rb(), rb(), rop(), ov(4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        exp_retired++;
      end
      K_LD: begin
        cyc("mem_addr", rb(), rb(), rop(), ov(4'b0010, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < mwait; i++)
          cyc("mem_rd_wait", 1'b0, rb(), rop(), ov(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        cyc("mem_rd", 1'b1, rb(), rop(), ov(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        cyc("mem_wb", rb(), rb(), rop(), ov(4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        exp_retired++;
      end
      K_ST: begin
        cyc("mem_addr", rb(), rb(), rop(), ov(4'b0010, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < mwait; i++)
          cyc("mem_wr_wait", 1'b0, rb(), rop(), ov(4'b0000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        cyc("mem_wr", 1'b1, rb(), rop(), ov(4'b0000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        exp_retired++;
      end
      K_CBZ: begin
        cyc("cbz", rb(), zz, rop(),
            ov(4'b0111, 1, 0, zz ? 1 : 0, 1, 0, 0, 0, 0, 0, 1, 0));
        exp_retired++;
      end
      K_B: begin
        cyc("jump", rb(), rb(), rop(), ov(4'b0000, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        exp_retired++;
      end
      default: begin
        cyc("illegal", rb(), rb(), rop(), ov(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      end
    endcase
    #1;
    chk("retired", retired, exp_retired);
    $display("instr op=%b kind=%0d fetch_wait=%0d mem_wait=%0d z=%0d retired=%0d",
             op, k, fw, mwait, zz, retired);
  endtask

  initial begin
    int          sel;
    logic [10:0] op;

    // Reset held with mem_ready high: write enables must stay low
    #12;
    chk("reset_outputs", {16'h0, obs}, {16'h0, ov(4'b0010, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0)});
    chk("reset_retired", retired, 32'h0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b1;

    exec_instr(11'b10001011000, 0, 0, 1'b0);
    exec_instr(11'b11111000010, 1, 3, 1'b0);
    exec_instr(11'b10110100101, 0, 0, 1'b1);
    exec_instr(11'b10110100010, 2, 0, 1'b0);
    exec_instr(11'b11111111111, 0, 0, 1'b0);
    exec_instr(11'b11111000000, 0, 2, 1'b1);
    exec_instr(11'b00010111011, 1, 0, 1'b0);

    // Reset asserted in the middle of a store wait
    cyc("fetch", 1'b1, 1'b0, rop(), ov(4'b0010, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
    cyc("decode", 1'b0, 1'b0, 11'b11111000000, ov(4'b0010, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    cyc("mem_addr", 1'b0, 1'b0, rop(), ov(4'b0010, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("mem_wr_wait", 1'b0, 1'b0, rop(), ov(4'b0000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("pre_rst_mem_write", {31'h0, mem_write}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_outputs", {16'h0, obs}, {16'h0, ov(4'b0010, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0)});
    chk("rst_mid_wr_retired", retired, 32'h0);
    exp_retired = '0;
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b1;

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       op = r_ops[$urandom_range(0, 3)];
        1:       op = 11'b11111000010;
        2:       op = 11'b11111000000;
        3:       op = {8'b10110100, 3'($urandom)};
        4:       op = {6'b000101, 5'($urandom)};
        default: begin
          op = rop();
          while (kind(op) != K_BAD) op = rop();
        end
      endcase
      exec_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb());
    end

    // Preload the counter just below the wrap point
    @(negedge clk);
    mem_ready = 1'b0;
    force dut.retired_reg = 32'hFFFF_FFFE;
    #1;
    release dut.retired_reg;
    exp_retired = 32'hFFFF_FFFE;
    #1;
    chk("preload", retired, exp_retired);
    exec_instr(11'b00010100000, 0, 0, 1'b0);
    exec_instr(11'b00010111111, 0, 0, 1'b0);
    chk("wrap_zero", retired, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 opcode  input  11  instruction bits [31:21], sampled only in DECODE.
REQ-004 z  input  1  ALU zero flag, combinational from the ALU in the same cycle.
REQ-005 mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-006 ALU_Sel  output  4  ALU operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 pass B, 1100 NOR.
REQ-007 alu_src_a  output  1  0=PC, 1=register A.
REQ-008 alu_src_b  output  2  00=register B, 01=constant 4, 10=sign-extended imm, 11=imm<<2.
REQ-009 pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, mem_to_reg, reg2loc  output  1 each  datapath enables/selects (pc_src 0=ALU result, 1=ALUOut register).
REQ-010 illegal  output  1  one-cycle pulse on an unrecognised opcode.
REQ-011 retired  output  32  count of completed instructions.

Function
REQ-012 States SHALL be FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, CBZ, JUMP, ILLEGAL.
REQ-013 Outputs SHALL be Moore-decoded from state; unlisted outputs in a state SHALL be 0.
REQ-014 FETCH: mem_read=1, ALU_Sel=0010, alu_src_a=0, alu_src_b=01; ir_write=pc_write=mem_ready; stay until mem_ready=1, then DECODE.
REQ-015 DECODE: ALU_Sel=0010, alu_src_a=0, alu_src_b=11 (branch target into ALUOut); reg2loc=1 for STUR/CBZ; next state by opcode.
REQ-016 Opcode map: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC_R; LDUR 11111000010, STUR 11111000000 -> MEM_ADDR; CBZ 10110100xxx -> CBZ; B 000101xxxxx -> JUMP; other -> ILLEGAL.
REQ-017 EXEC_R: alu_src_a=1, alu_src_b=00, ALU_Sel from opcode (ADD 0010, SUB 0110, AND 0000, ORR 0001); then R_WB.
REQ-018 R_WB: reg_write=1, mem_to_reg=0; then FETCH.
REQ-019 MEM_ADDR: alu_src_a=1, alu_src_b=10, ALU_Sel=0010; LDUR -> MEM_RD, STUR -> MEM_WR.
REQ-020 MEM_RD: mem_read=1; hold until mem_ready, then MEM_WB; MEM_WB: reg_write=1, mem_to_reg=1; then FETCH.
REQ-021 MEM_WR: mem_write=1, reg2loc=1; hold until mem_ready, then FETCH.
REQ-022 CBZ: alu_src_a=1, alu_src_b=00, ALU_Sel=0111, reg2loc=1, pc_src=1, pc_write=z; then FETCH.
REQ-023 JUMP: pc_write=1, pc_src=1; then FETCH; ILLEGAL: illegal=1, retired not incremented; then FETCH.
REQ-024 retired SHALL increment by 1 on leaving R_WB, MEM_WB, MEM_WR (with mem_ready), CBZ, JUMP; wraps 0xFFFFFFFF -> 0.
REQ-025 mem_ready outside FETCH/MEM_RD/MEM_WR SHALL be ignored.
REQ-026 Opcode SHALL be latched in DECODE; changes after DECODE SHALL not affect the current instruction.

Reset
REQ-027 rst_n low SHALL immediately force state=FETCH, retired=0, latched opcode=0, illegal=0, regardless of the current state.
REQ-028 While rst_n low, pc_write, ir_write, mem_write, reg_write SHALL be forced 0; first fetch begins on the first edge after release.

Structure
REQ-029 Package legv8_ctrl_pkg SHALL hold the state enum, opcode constants, and ALU_Sel code constants.
REQ-030 Sub-module alu_ctrl_decode (combinational opcode -> ALU_Sel) SHALL be instantiated for EXEC_R.

Verification
REQ-031 ADD opcode, mem_ready=1 in FETCH -> FETCH, DECODE, EXEC_R (ALU_Sel=0010), R_WB (reg_write=1); retired 0->1.
REQ-032 LDUR with mem_ready low 3 cycles in MEM_RD -> mem_read held 4 cycles; MEM_WB asserts mem_to_reg=1, reg_write=1.
REQ-033 CBZ with z=1 -> pc_write=1, pc_src=1, ALU_Sel=0111; repeat with z=0 -> pc_write=0; retired +1 both times.
REQ-034 opcode 11111111111 -> ILLEGAL, illegal pulse exactly 1 cycle, retired unchanged, back to FETCH.
REQ-035 rst_n low mid-MEM_WR -> mem_write drops immediately, state=FETCH, retired=0.
REQ-036 Preload retired near 0xFFFFFFFF via 2^32-1 B instructions (or force) -> next retire wraps to 0.
